// File: rtl/counter_sequencer_if.sv
// Command channel for counter_sequencer: {start value, run length} offered over valid/ready.
`timescale 1ns/1ps
interface counter_sequencer_if #(
  parameter int WIDTH = 5,
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_start, output cmd_len, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_start, input  cmd_len, output cmd_ready);
endinterface

// File: rtl/counter_sequencer.sv
// Loads an external up-counter, enables it for a commanded number of cycles and
// reports the settled count (optionally cut short by abort).
`timescale 1ns/1ps
module counter_sequencer #(
  parameter int WIDTH = 5,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_,
  counter_sequencer_if.slave   cmd,
  input  logic                 abort,
  output logic                 ctr_load,
  output logic [WIDTH-1:0]     ctr_data,
  output logic                 ctr_enable,
  input  logic [WIDTH-1:0]     ctr_count,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 aborted
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]   ctr_data_q, ctr_data_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               abort_flag_q, abort_flag_d;
  logic               ctr_load_q, ctr_enable_q, busy_q, cmd_ready_q;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    ctr_data_d   = ctr_data_q;
    result_d     = result_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    abort_flag_d = abort_flag_q;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          ctr_data_d   = cmd.cmd_start;
          remaining_d  = cmd.cmd_len;
          abort_flag_d = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          abort_flag_d = 1'b1;
          state_d      = DONE;
        end else if (remaining_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        remaining_d = remaining_q - LEN_W'(1);
        if (abort) begin
          abort_flag_d = 1'b1;
          state_d      = DONE;
        end else if (remaining_q == LEN_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Counter has absorbed the last enable by now, so its count is final.
        result_d  = ctr_count;
        done_d    = 1'b1;
        aborted_d = abort_flag_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they always equal a decode of state_q.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      ctr_data_q   <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_flag_q <= 1'b0;
      ctr_load_q   <= 1'b0;
      ctr_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      ctr_data_q   <= ctr_data_d;
      result_q     <= result_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_flag_q <= abort_flag_d;
      ctr_load_q   <= (state_d == LOAD);
      ctr_enable_q <= (state_d == RUN);
      busy_q       <= (state_d != IDLE);
      cmd_ready_q  <= (state_d == IDLE);
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign ctr_load      = ctr_load_q;
  assign ctr_enable    = ctr_enable_q;
  assign ctr_data      = ctr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized and directed bench for counter_sequencer with a behavioural counter
// and a per-command reference model of enables, latency and result.
`timescale 1ns/1ps
module tb_counter_sequencer;

  localparam int WIDTH = 5;
  localparam int LEN_W = 4;
  localparam int BOUND = 40;

  logic             clk = 1'b0;
  logic             rst_;
  logic             abort;
  logic             ctr_load;
  logic [WIDTH-1:0] ctr_data;
  logic             ctr_enable;
  logic [WIDTH-1:0] ctr_count = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             aborted;

  int num_checks = 0;
  int num_errors = 0;

  counter_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) cmd_if ();

  counter_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .cmd        (cmd_if.slave),
    .abort      (abort),
    .ctr_load   (ctr_load),
    .ctr_data   (ctr_data),
    .ctr_enable (ctr_enable),
    .ctr_count  (ctr_count),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  // The loadable counter the sequencer drives: load wins over enable.
  always @(posedge clk) begin
    if (ctr_load)        ctr_count <= ctr_data;
    else if (ctr_enable) ctr_count <= ctr_count + 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one command in an idle cycle; returns just after the accepting edge.
  task automatic applyStimulus(input int start, input int len, input bit keep_valid);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_start = WIDTH'(start);
    cmd_if.cmd_len   = LEN_W'(len);
    abort            = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    if (!keep_valid) cmd_if.cmd_valid = 1'b0;
    abort = 1'b0;
  endtask

  // Follows a command from cycle 1 after acceptance until done, checking it against the model.
  // abort_cycle counts cycles after acceptance (1 = load cycle); 0 means no abort.
  task automatic waitDone(input int start, input int len, input int abort_cycle, input string tag);
    bit effective;
    int exp_enables, exp_done_cyc, exp_result;
    int loads, enables, done_cyc;
    bit done_seen, busy_ok, data_ok, ready_at_done, busy_at_done, load_first;
    effective    = (abort_cycle != 0) && (abort_cycle <= len + 1);
    exp_enables  = effective ? abort_cycle - 1 : len;
    exp_done_cyc = effective ? abort_cycle + 2 : len + 3;
    exp_result   = (start + exp_enables) % (1 << WIDTH);
    loads = 0; enables = 0; done_cyc = 0;
    done_seen = 0; busy_ok = 1; data_ok = 1; ready_at_done = 0; busy_at_done = 1; load_first = 0;
    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      @(negedge clk);
      abort = (cyc == abort_cycle);
      if (done) begin
        done_seen     = 1;
        done_cyc      = cyc;
        ready_at_done = cmd_if.cmd_ready;
        busy_at_done  = busy;
        if (ctr_data !== WIDTH'(start)) data_ok = 0;
        break;
      end
      if (cyc == 1) load_first = ctr_load;
      if (ctr_load) loads++;
      if (ctr_enable) enables++;
      if (!busy || cmd_if.cmd_ready) busy_ok = 0;
      if (ctr_data !== WIDTH'(start)) data_ok = 0;
    end
    abort = 1'b0;
    checkOutput({tag, ".done_seen"}, done_seen, 1);
    checkOutput({tag, ".done_cycle"}, done_cyc, exp_done_cyc);
    checkOutput({tag, ".result"}, result, exp_result);
    checkOutput({tag, ".aborted"}, aborted, effective);
    checkOutput({tag, ".loads"}, loads, 1);
    checkOutput({tag, ".load_first"}, load_first, 1);
    checkOutput({tag, ".enables"}, enables, exp_enables);
    checkOutput({tag, ".busy_not_ready"}, busy_ok, 1);
    checkOutput({tag, ".data_stable"}, data_ok, 1);
    checkOutput({tag, ".ready_at_done"}, ready_at_done, 1);
    checkOutput({tag, ".idle_at_done"}, busy_at_done, 0);
  endtask

  task automatic runCommand(input int start, input int len, input int abort_cycle, input string tag);
    int exp_result;
    exp_result = (start + ((abort_cycle != 0 && abort_cycle <= len + 1) ? abort_cycle - 1 : len)) % (1 << WIDTH);
    applyStimulus(start, len, 0);
    waitDone(start, len, abort_cycle, tag);
    @(negedge clk);
    checkOutput({tag, ".done_width"}, done, 0);
    checkOutput({tag, ".result_held"}, result, exp_result);
  endtask

  initial begin
    int start, len, abort_cycle, gap;
    rst_             = 1'b0;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_start = '0;
    cmd_if.cmd_len   = '0;
    #12;
    checkOutput("reset.cmd_ready", cmd_if.cmd_ready, 1);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.ctr_load", ctr_load, 0);
    checkOutput("reset.ctr_enable", ctr_enable, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.result", result, 0);
    checkOutput("reset.ctr_data", ctr_data, 0);
    @(negedge clk);
    rst_ = 1'b1;

    runCommand(5'b10101, 5, 0, "t1");
    runCommand(30, 4, 0, "t2_wrap");
    runCommand(5'b01010, 0, 0, "t3_len0");
    runCommand(0, 10, 3, "t4_abort");
    runCommand(17, 6, 7, "abort_last_run");
    runCommand(9, 3, 1, "abort_in_load");
    runCommand(4, 2, 4, "abort_in_done");
    runCommand(31, 15, 0, "max_len");

    // Back-to-back with cmd_valid held: second command waits until the done cycle.
    applyStimulus(12, 3, 1);
    cmd_if.cmd_start = WIDTH'(25);
    cmd_if.cmd_len   = LEN_W'(9);
    waitDone(12, 3, 0, "b2b_first");
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    waitDone(25, 9, 0, "b2b_second");

    for (int n = 0; n < 20; n++) begin
      start       = $urandom_range(0, (1 << WIDTH) - 1);
      len         = $urandom_range(0, (1 << LEN_W) - 1);
      abort_cycle = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len + 3) : 0;
      gap         = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        abort = 1'($urandom_range(0, 1));
      end
      runCommand(start, len, abort_cycle, "rand");
    end

    // Asynchronous reset in the middle of a run.
    applyStimulus(7, 8, 0);
    repeat (3) @(negedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    checkOutput("midreset.ctr_enable", ctr_enable, 0);
    checkOutput("midreset.busy", busy, 0);
    checkOutput("midreset.cmd_ready", cmd_if.cmd_ready, 1);
    checkOutput("midreset.result", result, 0);
    checkOutput("midreset.done", done, 0);
    checkOutput("midreset.aborted", aborted, 0);
    @(negedge clk);
    rst_ = 1'b1;
    runCommand(3, 2, 0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
